// File: rtl/riscv_mem_stage.sv
// MEM stage of the RV32I pipeline: issues loads/stores on a req/ack data bus,
// stalls the upstream pipeline until the access completes, aligns and extends
// load data, and forwards writeback control to the MEM/WB register.
module riscv_mem_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mem_ctrl_mem_read,
  input  logic            i_mem_ctrl_mem_write,
  input  logic [2:0]      i_mem_funct3,
  input  logic            i_mem_ctrl_reg_write,
  input  logic            i_mem_ctrl_rd_src,
  input  logic [4:0]      i_mem_rd_addr,
  input  logic [XLEN-1:0] i_mem_rd_result,
  input  logic [XLEN-1:0] i_mem_store_data,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_mem_stall,
  output logic            o_misaligned,
  output logic            o_bus_err,
  output logic            o_wb_ctrl_reg_write,
  output logic            o_wb_ctrl_rd_src,
  output logic [4:0]      o_wb_rd_addr,
  output logic [XLEN-1:0] o_wb_rd_result,
  output logic [XLEN-1:0] o_wb_read_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

  logic [1:0]      state_q, state_d;
  logic [9:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            bus_err_q, bus_err_d;

  logic op, is_store, is_load, legal, fault, issue, timeout_hit;
  logic [1:0] addr_lo;

  // Decode the access: legality, alignment and whether a new request starts.
  always_comb begin
    op       = i_mem_ctrl_mem_read | i_mem_ctrl_mem_write;
    is_store = i_mem_ctrl_mem_write;
    is_load  = i_mem_ctrl_mem_read & ~i_mem_ctrl_mem_write;
    addr_lo  = i_mem_rd_result[1:0];
    if (is_store) legal = (i_mem_funct3 inside {3'b000, 3'b001, 3'b010});
    else          legal = (i_mem_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    fault = op & (~legal
                  | ((i_mem_funct3[1:0] == 2'b01) & addr_lo[0])
                  | ((i_mem_funct3[1:0] == 2'b10) & (addr_lo != 2'b00)));
    issue       = (state_q == S_IDLE) & op & ~fault;
    timeout_hit = (state_q == S_WAIT) & (cnt_q == TIMEOUT_C);
  end

  // Access sequencer: IDLE -> (WAIT_ACK) -> DONE -> IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          if (i_dmem_ack) begin
            rdata_d = i_dmem_rdata;
            state_d = S_DONE;
          end else begin
            cnt_d   = 10'd1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_dmem_ack) begin
          rdata_d = i_dmem_rdata;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, timeout counter, captured read word and bus-error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: the capture register is a single word, so it is reset along with the FSM; a real memory array would not be.
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Bus drive: address, lane-replicated write data and byte enables.
  always_comb begin
    o_dmem_req  = ~i_rst & (issue | ((state_q == S_WAIT) & ~timeout_hit));
    o_mem_stall = ~i_rst & (issue | (state_q == S_WAIT));
    o_dmem_we   = is_store;
    o_dmem_addr = {i_mem_rd_result[XLEN-1:2], 2'b00};
    case (i_mem_funct3[1:0])
      2'b00:   o_dmem_wdata = {(XLEN/8){i_mem_store_data[7:0]}};
      2'b01:   o_dmem_wdata = {(XLEN/16){i_mem_store_data[15:0]}};
      default: o_dmem_wdata = i_mem_store_data;
    endcase
    o_dmem_be = 4'b1111;
    if (is_store) begin
      case (i_mem_funct3[1:0])
        2'b00:   o_dmem_be = 4'b0001 << addr_lo;
        2'b01:   o_dmem_be = addr_lo[1] ? 4'b1100 : 4'b0011;
        default: o_dmem_be = 4'b1111;
      endcase
    end
  end

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  // Load alignment and extension from the captured word, plus writeback pass-through.
  always_comb begin
    case (addr_lo)
      2'b00:   ld_byte = rdata_q[7:0];
      2'b01:   ld_byte = rdata_q[15:8];
      2'b10:   ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = addr_lo[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (i_mem_funct3)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = rdata_q;
    endcase
    o_wb_read_data      = ((state_q == S_DONE) & is_load) ? ld_ext : '0;
    o_misaligned        = fault;
    o_bus_err           = bus_err_q;
    o_wb_ctrl_reg_write = i_mem_ctrl_reg_write & ~fault;
    o_wb_ctrl_rd_src    = i_mem_ctrl_rd_src;
    o_wb_rd_addr        = i_mem_rd_addr;
    o_wb_rd_result      = i_mem_rd_result;
  end

endmodule
